// File: rtl/adc_frame_fifo.sv
// Frame FIFO: gathers one sample per ADC channel into a sequence-tagged frame, popped a word at a time.
// Optional macro ADC_FRAME_CHECKSUM_EN appends an XOR checksum word to every frame.
module adc_frame_fifo #(
   parameter int FRAME_DEPTH = 8,
   parameter int PTR_W       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      adc_ch0,
   input  logic [15:0]      adc_ch1,
   input  logic [15:0]      adc_ch2,
   input  logic [15:0]      adc_ch3,
   input  logic [3:0]       adc_data_valid,
   input  logic             flush,
   input  logic             rd_req,
   input  logic             clr_flags,
   output logic [15:0]      rd_data,
   output logic             rd_valid,
   output logic [PTR_W:0]   frame_count,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             overflow,
   output logic             underflow,
   output logic             misalign,
   output logic [15:0]      seq_num
);

`ifdef ADC_FRAME_CHECKSUM_EN
   localparam int NW = 6;
`else
   localparam int NW = 5;
`endif
   localparam logic [2:0]     LAST  = 3'(NW - 1);
   localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FRAME_DEPTH);

   logic [15:0]      mem [FRAME_DEPTH][NW];
   logic [15:0]      hold [4];
   logic [15:0]      ch [4];
   logic [15:0]      entry [NW];
   logic [3:0]       mask;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [2:0]       word_idx;

   logic complete;
   logic rd_ok;
   logic pop;
   logic wr_ok;
   logic ovf_ev;
   logic unf_ev;
   logic mis_ev;

   assign fifo_empty = (frame_count == '0);
   assign fifo_full  = (frame_count == DEPTH);

   // The mask is registered, so the frame lands one cycle after the last strobe.
   assign complete = (mask == 4'hF);
   assign rd_ok    = rd_req & ~fifo_empty & ~flush;
   assign pop      = rd_ok & (word_idx == LAST);
   assign wr_ok    = complete & ~flush & (~fifo_full | pop);
   assign ovf_ev   = complete & ~flush & fifo_full & ~pop;
   assign unf_ev   = rd_req & fifo_empty & ~flush;
   assign mis_ev   = (|(adc_data_valid & mask)) & ~complete;

   always_comb begin
      ch[0] = adc_ch0;
      ch[1] = adc_ch1;
      ch[2] = adc_ch2;
      ch[3] = adc_ch3;
   end

   always_comb begin
      entry[0] = seq_num;
      entry[1] = hold[0];
      entry[2] = hold[1];
      entry[3] = hold[2];
      entry[4] = hold[3];
`ifdef ADC_FRAME_CHECKSUM_EN
      entry[5] = seq_num ^ hold[0] ^ hold[1] ^ hold[2] ^ hold[3];
`endif
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (adc_data_valid[i]) hold[i] <= ch[i];
      end
      if (wr_ok) begin
         for (int k = 0; k < NW; k++) mem[wr_ptr][k] <= entry[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         word_idx    <= '0;
         frame_count <= '0;
         seq_num     <= '0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         rd_valid  <= rd_ok;
         overflow  <= (overflow & ~clr_flags) | ovf_ev;
         underflow <= (underflow & ~clr_flags) | unf_ev;
         misalign  <= (misalign & ~clr_flags) | mis_ev;

         if (rd_ok) rd_data <= mem[rd_ptr][word_idx];

         if (complete && !flush) seq_num <= seq_num + 16'd1;

         if (flush) begin
            mask        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_idx    <= '0;
            frame_count <= '0;
         end else begin
            // A strobe arriving as the mask clears starts the next frame.
            if (complete) mask <= adc_data_valid;
            else          mask <= mask | adc_data_valid;

            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);

            if (rd_ok) begin
               if (pop) begin
                  word_idx <= '0;
                  rd_ptr   <= rd_ptr + PTR_W'(1);
               end else begin
                  word_idx <= word_idx + 3'd1;
               end
            end

            unique case ({wr_ok, pop})
               2'b10:   frame_count <= frame_count + (PTR_W + 1)'(1);
               2'b01:   frame_count <= frame_count - (PTR_W + 1)'(1);
               default: frame_count <= frame_count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Directed bench for adc_frame_fifo with a word scoreboard.
// Honours ADC_FRAME_CHECKSUM_EN for frame length.
module tb_adc_frame_fifo;

`ifdef ADC_FRAME_CHECKSUM_EN
   localparam int NW = 6;
`else
   localparam int NW = 5;
`endif
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] adc_ch0, adc_ch1, adc_ch2, adc_ch3;
   logic [3:0]  adc_data_valid;
   logic        flush, rd_req, clr_flags;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [3:0]  frame_count;
   logic        fifo_empty, fifo_full;
   logic        overflow, underflow, misalign;
   logic [15:0] seq_num;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q [$];
   int mcnt = 0;
   int widx = 0;
   logic [15:0] mseq = 16'd0;
   logic [15:0] last_data = 16'd0;

   adc_frame_fifo dut (
      .clk(clk), .rst_n(rst_n),
      .adc_ch0(adc_ch0), .adc_ch1(adc_ch1),
      .adc_ch2(adc_ch2), .adc_ch3(adc_ch3),
      .adc_data_valid(adc_data_valid),
      .flush(flush), .rd_req(rd_req), .clr_flags(clr_flags),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .frame_count(frame_count),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .overflow(overflow), .underflow(underflow),
      .misalign(misalign), .seq_num(seq_num)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model of a frame completing: stored if room, else dropped.
   task automatic model_complete(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
      if (mcnt < DEPTH) begin
         exp_q.push_back(mseq);
         exp_q.push_back(a);
         exp_q.push_back(b);
         exp_q.push_back(c);
         exp_q.push_back(d);
         if (NW == 6) exp_q.push_back(mseq ^ a ^ b ^ c ^ d);
         mcnt++;
      end
      mseq = mseq + 16'd1;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
      adc_ch0 = a; adc_ch1 = b; adc_ch2 = c; adc_ch3 = d;
      adc_data_valid = 4'hF;
      tick();
      adc_data_valid = 4'h0;
      tick();
      model_complete(a, b, c, d);
   endtask

   task automatic check_word();
      chk("rd_valid", {31'd0, rd_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL rd_data observed=%h expected=<none>", rd_data);
      end else begin
         last_data = exp_q.pop_front();
         chk("rd_data", {16'd0, rd_data}, {16'd0, last_data});
      end
      widx++;
      if (widx == NW) begin
         widx = 0;
         mcnt--;
      end
   endtask

   task automatic read_word();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_word();
   endtask

   initial begin
      rst_n = 1'b0;
      adc_ch0 = '0; adc_ch1 = '0; adc_ch2 = '0; adc_ch3 = '0;
      adc_data_valid = '0;
      flush = 1'b0; rd_req = 1'b0; clr_flags = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_count", {28'd0, frame_count}, 32'd0);
      chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
      chk("rst_seq", {16'd0, seq_num}, 32'd0);
      chk("rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_data", {16'd0, rd_data}, 32'd0);

      // single-cycle frame
      send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      chk("f1_count", {28'd0, frame_count}, 32'd1);
      chk("f1_seq", {16'd0, seq_num}, {16'd0, mseq});
      for (int i = 0; i < NW; i++) read_word();
      chk("f1_empty", {31'd0, fifo_empty}, 32'd1);

      // staggered strobes
      for (int c = 0; c < 10; c++) begin
         adc_data_valid = 4'h0;
         if (c == 0) begin adc_data_valid[2] = 1'b1; adc_ch2 = 16'h5003; end
         if (c == 3) begin adc_data_valid[0] = 1'b1; adc_ch0 = 16'h5001; end
         if (c == 7) begin adc_data_valid[3] = 1'b1; adc_ch3 = 16'h5004; end
         if (c == 9) begin adc_data_valid[1] = 1'b1; adc_ch1 = 16'h5002; end
         tick();
      end
      adc_data_valid = 4'h0;
      chk("stag_pending", {28'd0, frame_count}, 32'd0);
      tick();
      model_complete(16'h5001, 16'h5002, 16'h5003, 16'h5004);
      chk("stag_count", {28'd0, frame_count}, 32'd1);
      chk("stag_seq", {16'd0, seq_num}, {16'd0, mseq});
      for (int i = 0; i < NW; i++) read_word();

      // overflow: nine frames into eight slots
      for (int i = 0; i < 9; i++) begin
         send_frame(16'hA000 + 16'(i), 16'hB000 + 16'(i),
                    16'hC000 + 16'(i), 16'hD000 + 16'(i));
      end
      chk("ovf_full", {31'd0, fifo_full}, 32'd1);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      chk("ovf_count", {28'd0, frame_count}, 32'd8);
      chk("ovf_seq", {16'd0, seq_num}, {16'd0, mseq});
      for (int i = 0; i < DEPTH * NW; i++) read_word();
      chk("ovf_drained", {31'd0, fifo_empty}, 32'd1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);

      // underflow
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("unf_valid", {31'd0, rd_valid}, 32'd0);
      chk("unf_flag", {31'd0, underflow}, 32'd1);
      chk("unf_hold", {16'd0, rd_data}, {16'd0, last_data});

      // misalign: ch1 strobed twice
      adc_ch1 = 16'hAAAA; adc_data_valid = 4'b0010;
      tick();
      chk("mis_pre", {31'd0, misalign}, 32'd0);
      adc_ch1 = 16'hBBBB;
      tick();
      chk("mis_flag", {31'd0, misalign}, 32'd1);
      adc_ch0 = 16'h0C00; adc_ch2 = 16'h0C02; adc_ch3 = 16'h0C03;
      adc_ch1 = 16'hEEEE;
      adc_data_valid = 4'b1101;
      tick();
      adc_data_valid = 4'h0;
      tick();
      model_complete(16'h0C00, 16'hBBBB, 16'h0C02, 16'h0C03);
      for (int i = 0; i < NW; i++) read_word();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("clr_unf", {31'd0, underflow}, 32'd0);
      chk("clr_mis", {31'd0, misalign}, 32'd0);

      // full FIFO, last head word popped as a new frame lands
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(16'h7000 + 16'(i), 16'h7100 + 16'(i),
                    16'h7200 + 16'(i), 16'h7300 + 16'(i));
      end
      chk("fp_full", {31'd0, fifo_full}, 32'd1);
      for (int i = 0; i < NW - 1; i++) read_word();
      adc_ch0 = 16'h9990; adc_ch1 = 16'h9991;
      adc_ch2 = 16'h9992; adc_ch3 = 16'h9993;
      adc_data_valid = 4'hF;
      tick();
      adc_data_valid = 4'h0;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      check_word();
      model_complete(16'h9990, 16'h9991, 16'h9992, 16'h9993);
      chk("fp_count", {28'd0, frame_count}, 32'd8);
      chk("fp_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < DEPTH * NW; i++) read_word();
      chk("fp_empty", {31'd0, fifo_empty}, 32'd1);

      // flush mid-read with a concurrent frame write
      send_frame(16'h1234, 16'h2345, 16'h3456, 16'h4567);
      read_word();
      read_word();
      adc_data_valid = 4'hF;
      tick();
      adc_data_valid = 4'h0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      mcnt = 0;
      widx = 0;
      chk("fl_count", {28'd0, frame_count}, 32'd0);
      chk("fl_empty", {31'd0, fifo_empty}, 32'd1);
      chk("fl_seq", {16'd0, seq_num}, {16'd0, mseq});
      chk("fl_ovf", {31'd0, overflow}, 32'd0);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("fl_rdv", {31'd0, rd_valid}, 32'd0);
      chk("fl_unf", {31'd0, underflow}, 32'd1);

      // fresh frame after reset, checksum word when enabled
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      mcnt = 0; widx = 0; mseq = 16'd0;
      chk("rst2_unf", {31'd0, underflow}, 32'd0);
      send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      for (int i = 0; i < 5; i++) read_word();
`ifdef ADC_FRAME_CHECKSUM_EN
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("csum_valid", {31'd0, rd_valid}, 32'd1);
      chk("csum_word", {16'd0, rd_data}, 32'h4444);
      void'(exp_q.pop_front());
      mcnt--;
      widx = 0;
`endif
      chk("end_empty", {31'd0, fifo_empty}, 32'd1);
      chk("end_q", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
